// File: rtl/tpu_row_loader_if.sv
// Start/stream/SRAM-write/status bundle of tpu_row_loader; slave = loader side, master = host side.
// No latency of its own; the stream is valid/ready with s_ready owned by the loader.
interface tpu_row_loader_if #(
  parameter int W  = 16,
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          start_valid;
  logic [AW-1:0] start_addr;
  logic [AW:0]   start_rows;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic [AW-1:0] host_wr_addr;
  logic          host_wr_en;
  logic [DW-1:0] host_wr_data [W];
  logic          busy;
  logic          done;
  logic          err;
  logic [15:0]   stall_cnt;

  modport slave (
    input  start_valid, start_addr, start_rows, s_valid, s_data, s_last,
    output s_ready, host_wr_addr, host_wr_en, host_wr_data, busy, done, err, stall_cnt
  );

  modport master (
    output start_valid, start_addr, start_rows, s_valid, s_data, s_last,
    input  s_ready, host_wr_addr, host_wr_en, host_wr_data, busy, done, err, stall_cnt
  );
endinterface

// File: rtl/tpu_row_loader.sv
// Packs W stream words per row and writes N rows to SRAM from a base address; TPU_ROW_LOADER_STALL_CNT_EN adds a starvation counter.
// Write strobe one cycle after the row's last word (W+1 cycles/row); s_ready is high only while filling a row.
module tpu_row_loader #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 16,
  parameter int DATA_WIDTH_ACCUM     = 32,
  parameter int ADDR_WIDTH           = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  tpu_row_loader_if.slave bus
);
  localparam int W  = SYSTOLIC_ARRAY_WIDTH;
  localparam int DW = DATA_WIDTH_ACCUM;
  localparam int AW = ADDR_WIDTH;
  localparam int LW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [LW-1:0]   r_lane_idx;
  logic [DW-1:0]   r_lane [W];
  logic [DW-1:0]   r_wr_data [W];
  logic [AW-1:0]   r_addr;
  logic [AW:0]     r_rows_left;
  logic            r_term;
  logic            r_err;

  logic w_accept;
  logic w_lane_full;
  logic w_final;
  logic w_row_done;
  logic w_start_ok;

  assign w_accept    = (r_state == S_FILL) && bus.s_valid;
  assign w_lane_full = (r_lane_idx == LW'(W - 1));
  assign w_final     = (r_rows_left == (AW + 1)'(1));
  assign w_row_done  = w_accept && (bus.s_last || w_lane_full);
  assign w_start_ok  = (r_state == S_IDLE) && bus.start_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start_valid) begin
          w_state_nxt = (bus.start_rows == '0) ? S_DONE : S_FILL;
        end
      end
      S_FILL: begin
        if (w_row_done) begin
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: w_state_nxt = r_term ? S_DONE : S_FILL;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane_idx  <= '0;
      r_addr      <= '0;
      r_rows_left <= '0;
      r_term      <= 1'b0;
      r_err       <= 1'b0;
      for (int i = 0; i < W; i++) begin
        r_lane[i]    <= '0;
        r_wr_data[i] <= '0;
      end
    end else begin
      if (w_start_ok) begin
        r_addr      <= bus.start_addr;
        r_rows_left <= bus.start_rows;
        r_lane_idx  <= '0;
        r_err       <= 1'b0;
      end
      if (w_accept) begin
        r_lane[r_lane_idx] <= bus.s_data;
        r_lane_idx         <= r_lane_idx + LW'(1);
      end
      // Output row is built here so host_wr_data only moves when a row completes;
      // lanes past an early s_last are zero-filled.
      if (w_row_done) begin
        for (int i = 0; i < W; i++) begin
          if (LW'(i) == r_lane_idx) begin
            r_wr_data[i] <= bus.s_data;
          end else if (LW'(i) < r_lane_idx) begin
            r_wr_data[i] <= r_lane[i];
          end else begin
            r_wr_data[i] <= '0;
          end
        end
        r_term <= bus.s_last || w_final;
        r_err  <= r_err | (bus.s_last ? !(w_lane_full && w_final) : w_final);
      end
      if (r_state == S_WRITE) begin
        r_addr      <= r_addr + AW'(1);
        r_rows_left <= r_rows_left - (AW + 1)'(1);
        r_lane_idx  <= '0;
      end
    end
  end

  assign bus.s_ready      = (r_state == S_FILL);
  assign bus.host_wr_en   = (r_state == S_WRITE);
  assign bus.busy         = (r_state == S_FILL) || (r_state == S_WRITE);
  assign bus.done         = (r_state == S_DONE);
  assign bus.err          = r_err;
  assign bus.host_wr_addr = r_addr;
  assign bus.host_wr_data = r_wr_data;

`ifdef TPU_ROW_LOADER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_FILL) && !bus.s_valid && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign bus.stall_cnt = r_stall_cnt;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_tpu_row_loader.sv
// Randomized bench for tpu_row_loader against a row/transfer-level reference model, plus directed literal checks.
module tb_tpu_row_loader;
  localparam int W  = 4;
  localparam int DW = 32;
  localparam int AW = 4;

  typedef logic [DW-1:0] row_t [W];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tpu_row_loader_if #(.W(W), .DW(DW), .AW(AW)) bus ();

  tpu_row_loader #(
    .SYSTOLIC_ARRAY_WIDTH(W),
    .DATA_WIDTH_ACCUM(DW),
    .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Logs of observed DUT activity, used by the directed literal checks.
  logic [AW-1:0] wr_addr_log [$];
  row_t          wr_dat_log [$];
  int            wr_cyc_log [$];
  int            done_cnt = 0;
  int            done_cyc = 0;
  int            busy_cnt = 0;
  int            cyc = 0;

  // Reference model: expectations for the current cycle plus transfer bookkeeping.
  bit            m_busy, m_wr, m_done, m_err, m_term;
  int            m_addr, m_rows_left, m_wr_addr, m_stall;
  logic [DW-1:0] m_lanes [$];
  logic [DW-1:0] m_out_row [W];

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_wr = 0; m_done = 0; m_err = 0; m_term = 0;
      m_addr = 0; m_rows_left = 0; m_wr_addr = 0; m_stall = 0;
      m_lanes.delete();
      for (int i = 0; i < W; i++) m_out_row[i] = '0;
      chk("rst_ctrl", {bus.busy, bus.done, bus.err, bus.host_wr_en, bus.s_ready}, 0);
      chk("rst_addr", bus.host_wr_addr, 0);
      chk("rst_stall", bus.stall_cnt, 0);
      for (int i = 0; i < W; i++) chk($sformatf("rst_data[%0d]", i), bus.host_wr_data[i], 0);
    end else begin
      bit nb, nwr, nd, full;
      cyc++;
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("wr_en", bus.host_wr_en, m_wr);
      chk("s_ready", bus.s_ready, m_busy && !m_wr);
      chk("err", bus.err, m_err);
      for (int i = 0; i < W; i++) chk($sformatf("wr_data[%0d]", i), bus.host_wr_data[i], m_out_row[i]);
      if (m_wr) chk("wr_addr", bus.host_wr_addr, m_wr_addr);
`ifdef TPU_ROW_LOADER_STALL_CNT_EN
      chk("stall_cnt", bus.stall_cnt, m_stall);
`else
      chk("stall_cnt", bus.stall_cnt, 0);
`endif
      if (bus.host_wr_en) begin
        wr_addr_log.push_back(bus.host_wr_addr);
        wr_dat_log.push_back(bus.host_wr_data);
        wr_cyc_log.push_back(cyc);
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.busy) busy_cnt++;

      nb = m_busy; nwr = 0; nd = 0;
      if (!m_busy && !m_done && bus.start_valid) begin
        m_err = 0;
        m_stall = 0;
        if (bus.start_rows == 0) nd = 1;
        else begin
          nb = 1;
          m_addr = int'(bus.start_addr);
          m_rows_left = int'(bus.start_rows);
          m_lanes.delete();
        end
      end
      if (m_busy && !m_wr) begin
        if (!bus.s_valid) begin
          if (m_stall < 65535) m_stall++;
        end else begin
          m_lanes.push_back(bus.s_data);
          if (bus.s_last || m_lanes.size() == W) begin
            full = (m_lanes.size() == W);
            for (int i = 0; i < W; i++) m_out_row[i] = (i < m_lanes.size()) ? m_lanes[i] : '0;
            if (bus.s_last != (full && m_rows_left == 1)) m_err = 1;
            m_term = bus.s_last || (m_rows_left == 1);
            m_wr_addr = m_addr;
            m_lanes.delete();
            nwr = 1;
          end
        end
      end
      if (m_wr) begin
        m_addr = (m_addr + 1) % (1 << AW);
        m_rows_left--;
        if (m_term) begin
          nb = 0;
          nd = 1;
        end
      end
      m_busy = nb; m_wr = nwr; m_done = nd;
    end
  end

  // All drivers run from posedge+1 and return at posedge+1.
  task automatic do_start(input int a, input int n);
    bus.start_valid = 1'b1;
    bus.start_addr  = AW'(a);
    bus.start_rows  = (AW + 1)'(n);
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1/0, 2: random valid with stray starts.
  task automatic send(input int nw, input int lastk, input int mode, input int d0);
    int k = 0;
    int budget = 0;
    bit acc;
    while (k < nw && budget < 500) begin
      case (mode)
        0:       bus.s_valid = 1'b1;
        1:       bus.s_valid = (budget % 2 == 0);
        default: bus.s_valid = ($urandom_range(0, 2) != 0);
      endcase
      bus.s_data = DW'(d0 + k);
      bus.s_last = (k == lastk);
      if (mode == 2) begin
        bus.start_valid = ($urandom_range(0, 7) == 0);
        bus.start_addr  = AW'($urandom);
        bus.start_rows  = (AW + 1)'($urandom);
      end
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk); #1;
      if (acc) k++;
      budget++;
    end
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    bus.start_valid = 1'b0;
    chk("stream_accepted", k, nw);
  endtask

  task automatic wait_done(input string name);
    int b = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && b < 200) begin
      @(posedge clk); #1;
      b++;
    end
    chk(name, done_cnt - d0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int w0, d0, b0, n, a, kind, nw, lastk, mode;
    bus.start_valid = 0; bus.start_addr = '0; bus.start_rows = '0;
    bus.s_valid = 0; bus.s_data = '0; bus.s_last = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Two full rows, back-to-back stream.
    w0 = wr_addr_log.size();
    do_start(5, 2);
    send(8, 7, 0, 1);
    wait_done("t1_done");
    chk("t1_nwr", wr_addr_log.size() - w0, 2);
    chk("t1_addr0", wr_addr_log[w0], 5);
    chk("t1_addr1", wr_addr_log[w0+1], 6);
    for (int i = 0; i < W; i++) begin
      chk("t1_row0", wr_dat_log[w0][i], i + 1);
      chk("t1_row1", wr_dat_log[w0+1][i], i + 5);
    end
    chk("t1_wr_gap", wr_cyc_log[w0+1] - wr_cyc_log[w0], W + 1);
    chk("t1_done_lat", done_cyc - wr_cyc_log[w0+1], 1);
    chk("t1_err", bus.err, 0);

    // Zero-row transfer.
    w0 = wr_addr_log.size(); b0 = busy_cnt;
    do_start(3, 0);
    wait_done("t2_done");
    chk("t2_nwr", wr_addr_log.size() - w0, 0);
    chk("t2_busy", busy_cnt - b0, 0);

    // Address wrap.
    w0 = wr_addr_log.size();
    do_start(15, 2);
    send(8, 7, 0, 16);
    wait_done("t3_done");
    chk("t3_addr0", wr_addr_log[w0], 15);
    chk("t3_addr1", wr_addr_log[w0+1], 0);

    // Early s_last on word 6.
    w0 = wr_addr_log.size();
    do_start(0, 2);
    send(6, 5, 0, 1);
    wait_done("t4_done");
    chk("t4_nwr", wr_addr_log.size() - w0, 2);
    for (int i = 0; i < W; i++) chk("t4_row1", wr_dat_log[w0+1][i], (i < 2) ? i + 5 : 0);
    repeat (4) @(posedge clk);
    #1 chk("t4_err_sticky", bus.err, 1);

    // Toggling valid: same rows, 6 starved FILL cycles.
    w0 = wr_addr_log.size();
    do_start(5, 2);
    send(8, 7, 1, 1);
    wait_done("t5_done");
    for (int i = 0; i < W; i++) begin
      chk("t5_row0", wr_dat_log[w0][i], i + 1);
      chk("t5_row1", wr_dat_log[w0+1][i], i + 5);
    end
    chk("t5_err_cleared", bus.err, 0);
`ifdef TPU_ROW_LOADER_STALL_CNT_EN
    chk("t5_stall", bus.stall_cnt, 6);
`else
    chk("t5_stall", bus.stall_cnt, 0);
`endif

    // Reset mid-row aborts the transfer.
    w0 = wr_addr_log.size(); d0 = done_cnt;
    do_start(2, 2);
    send(2, -1, 0, 1);
    rst_n = 1'b0;
    #1 chk("t6_busy_now", {bus.busy, bus.s_ready}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_wr", wr_addr_log.size() - w0, 0);
    chk("t6_no_done", done_cnt - d0, 0);
    do_start(7, 1);
    send(4, 3, 0, 100);
    wait_done("t6_restart_done");
    chk("t6_addr", wr_addr_log[w0], 7);
    for (int i = 0; i < W; i++) chk("t6_row", wr_dat_log[w0][i], 100 + i);

    // Randomized transfers: correct, early and missing s_last, varied stream gaps.
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, 3);
      a = $urandom_range(0, (1 << AW) - 1);
      kind = $urandom_range(0, 3);
      mode = $urandom_range(0, 2);
      nw = n * W;
      lastk = nw - 1;
      if (kind == 2) begin
        lastk = $urandom_range(0, nw - 2);
        nw = lastk + 1;
      end else if (kind == 3) begin
        lastk = -1;
      end
      do_start(a, n);
      send(nw, lastk, mode, $urandom_range(0, 1 << 20));
      wait_done("rand_done");
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
